// File: rtl/note_voice_sched.sv
// Purpose : time-multiplexes one waveform LUT read port across NUM_VOICES voices and mixes their samples.
// Latency : tick at T -> agg_valid at T+1+sum(2 per enabled voice, 1 per disabled voice).
// Backpr. : agg_out/agg_valid held until agg_ack; ticks arriving while busy are dropped and flagged on overrun.
// Ports   : clk/rst (sync, active-high); sample_tick, voice_en, o_up, o_down control inputs;
//           lut_rd/lut_addr/lut_data shared LUT port (data one cycle after strobe);
//           agg_out/agg_valid/agg_ack mixed-sample handshake; busy, overrun status.
module note_voice_sched #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 12,
    parameter int STEP_W     = 8,
    parameter int SAMP_W     = 8,
    parameter int MIX_W      = SAMP_W + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic [NUM_VOICES-1:0] o_up,
    input  logic [NUM_VOICES-1:0] o_down,
    output logic                  lut_rd,
    output logic [IDX_W-1:0]      lut_addr,
    input  logic [SAMP_W-1:0]     lut_data,
    output logic [MIX_W-1:0]      agg_out,
    output logic                  agg_valid,
    input  logic                  agg_ack,
    output logic                  busy,
    output logic                  overrun
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [VW-1:0]     LAST_V   = VW'(NUM_VOICES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX = {1'b1, {(STEP_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACCUM, S_PRESENT} state_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       v_q, v_d;
    logic [IDX_W-1:0]    phase_q [NUM_VOICES];
    logic [IDX_W-1:0]    phase_d [NUM_VOICES];
    logic [STEP_W-1:0]   step_q  [NUM_VOICES];
    logic [STEP_W-1:0]   step_d  [NUM_VOICES];
    logic [MIX_W-1:0]    acc_q, acc_d;
    logic [MIX_W-1:0]    agg_out_q, agg_out_d;
    logic                overrun_q, overrun_d;
    logic                last_v;

    assign last_v = (v_q == LAST_V);

    // Octave control runs every cycle regardless of the scheduler; the phase
    // advance below always uses step_q, so a same-cycle octave change only
    // takes effect on the next advance.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            step_d[i] = step_q[i];
            if (o_up[i] && !o_down[i]) begin
                step_d[i] = (step_q[i] == STEP_MAX) ? STEP_MAX : (step_q[i] << 1);
            end else if (o_down[i] && !o_up[i]) begin
                step_d[i] = (step_q[i] <= STEP_ONE) ? STEP_ONE : (step_q[i] >> 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        acc_d     = acc_q;
        agg_out_d = agg_out_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            phase_d[i] = phase_q[i];
        end
        lut_rd    = 1'b0;
        lut_addr  = phase_q[v_q];
        // No frame queueing: any tick seen outside IDLE is lost.
        overrun_d = sample_tick && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (voice_en[v_q]) begin
                    lut_rd  = 1'b1;
                    state_d = S_ACCUM;
                end else if (last_v) begin
                    agg_out_d = acc_q;
                    state_d   = S_PRESENT;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            S_ACCUM: begin
                // lut_data answers the read strobed in the previous ISSUE cycle.
                acc_d        = acc_q + MIX_W'(lut_data);
                phase_d[v_q] = phase_q[v_q] + IDX_W'(step_q[v_q]);
                if (last_v) begin
                    agg_out_d = acc_d;
                    state_d   = S_PRESENT;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_PRESENT: begin
                if (agg_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            v_q       <= '0;
            acc_q     <= '0;
            agg_out_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                step_q[i]  <= STEP_ONE;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            acc_q     <= acc_d;
            agg_out_q <= agg_out_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= phase_d[i];
                step_q[i]  <= step_d[i];
            end
        end
    end

    assign agg_out   = agg_out_q;
    assign agg_valid = (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_note_voice_sched.sv
// Purpose : stimulus and checking for note_voice_sched (4 voices, default widths).
// Latency : n/a.
// Backpr. : drives agg_ack both promptly and with long holds.
module tb_note_voice_sched;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst, sample_tick, agg_ack;
    logic [3:0]  voice_en, o_up, o_down;
    logic        lut_rd;
    logic [11:0] lut_addr;
    logic [7:0]  lut_data;
    logic [10:0] agg_out;
    logic        agg_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    note_voice_sched dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
        .o_up(o_up), .o_down(o_down), .lut_rd(lut_rd), .lut_addr(lut_addr),
        .lut_data(lut_data), .agg_out(agg_out), .agg_valid(agg_valid),
        .agg_ack(agg_ack), .busy(busy), .overrun(overrun)
    );

    function automatic logic [7:0] lut_fn(input int a);
        if (a == 0) return 8'h10;
        if (a == 1) return 8'h20;
        return 8'((a ^ (a >> 4)) + 3);
    endfunction

    // LUT memory: answers one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        cyc++;
        lut_data <= lut_rd ? lut_fn(int'(lut_addr)) : 8'($urandom);
    end

    // ---------------- behavioural model ----------------
    // A frame is a work list built when the tick is accepted: per voice either
    // (read, accumulate) or (skip); one entry is consumed per cycle, then the
    // result is presented until acknowledged.
    typedef struct packed { logic [1:0] kind; logic [2:0] v; } item_t;
    localparam logic [1:0] K_READ = 2'd0, K_ACC = 2'd1, K_SKIP = 2'd2;

    item_t       q[$];
    bit          m_present, m_init;
    int          m_phase [NV];
    int          m_step  [NV];
    int          m_sum;
    bit          e_rd, e_valid, e_busy, e_ovr;
    logic [11:0] e_addr;
    logic [10:0] e_out;

    always @(posedge clk) begin : model
        item_t it;
        bit    was_busy;
        if (rst) begin
            q.delete();
            m_present = 0;
            m_sum     = 0;
            for (int i = 0; i < NV; i++) begin m_phase[i] = 0; m_step[i] = 1; end
            e_rd = 0; e_valid = 0; e_busy = 0; e_ovr = 0; e_addr = '0; e_out = '0;
            m_init = 1;
        end else if (m_init) begin
            was_busy = (q.size() != 0) || m_present;
            if (q.size() != 0) begin
                it = q.pop_front();
                if (it.kind == K_ACC)
                    m_phase[it.v] = (m_phase[it.v] + m_step[it.v]) % 4096;
                if (q.size() == 0) m_present = 1;
            end else if (m_present && agg_ack) begin
                m_present = 0;
            end
            e_ovr = sample_tick && was_busy;
            if (sample_tick && !was_busy) begin
                m_sum = 0;
                for (int i = 0; i < NV; i++) begin
                    if (voice_en[i]) begin
                        q.push_back('{K_READ, 3'(i)});
                        q.push_back('{K_ACC, 3'(i)});
                        m_sum += int'(lut_fn(m_phase[i]));
                    end else begin
                        q.push_back('{K_SKIP, 3'(i)});
                    end
                end
            end
            for (int i = 0; i < NV; i++) begin
                if (o_up[i] && !o_down[i])      m_step[i] = (m_step[i] >= 128) ? 128 : m_step[i] * 2;
                else if (o_down[i] && !o_up[i]) m_step[i] = (m_step[i] <= 1) ? 1 : m_step[i] / 2;
            end
            e_rd    = (q.size() != 0) && (q[0].kind == K_READ);
            e_addr  = e_rd ? 12'(m_phase[q[0].v]) : 12'd0;
            e_valid = m_present;
            if (m_present) e_out = 11'(m_sum);
            e_busy  = (q.size() != 0) || m_present;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit ok;
        if (m_init) begin
            ok = (busy === e_busy) && (agg_valid === e_valid) && (lut_rd === e_rd) &&
                 (overrun === e_ovr) && (!e_rd || lut_addr === e_addr) &&
                 (!e_valid || agg_out === e_out);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle %0d: busy,valid,rd,ovr=%b%b%b%b addr=%0d out=%0d, want %b%b%b%b addr=%0d out=%0d",
                         cyc, busy, agg_valid, lut_rd, overrun, lut_addr, agg_out,
                         e_busy, e_valid, e_rd, e_ovr, e_addr, e_out);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] up, input logic [3:0] dn, input int n);
        repeat (n) begin
            o_up = up; o_down = dn;
            nxt();
            o_up = '0; o_down = '0;
        end
    endtask

    // Tick, measure cycles to agg_valid, capture first read address, then ack.
    task automatic run_frame(input logic [3:0] en, output int lat, output int out, output int a0);
        voice_en    = en;
        sample_tick = 1'b1;
        nxt();
        sample_tick = 1'b0;
        lat = 1;
        a0  = -1;
        while (!agg_valid && lat < 40) begin
            if (lut_rd && a0 < 0) a0 = int'(lut_addr);
            nxt();
            lat++;
        end
        checks++;
        if (!agg_valid) begin
            errors++;
            $display("FAIL frame_timeout: agg_valid got 0 want 1 within 40 cycles");
        end
        out = int'(agg_out);
        agg_ack = 1'b1;
        nxt();
        agg_ack = 1'b0;
    endtask

    function automatic int pdiff(input int a, input int b);
        return ((b - a) + 4096) % 4096;
    endfunction

    initial begin
        int lat, out, a0, a1, ovr_cnt, k;
        bit stable;
        logic [10:0] saved;

        rst = 1'b1; sample_tick = 1'b0; agg_ack = 1'b0;
        voice_en = '0; o_up = '0; o_down = '0;
        nxt(); nxt(); nxt();
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_agg_valid", int'(agg_valid), 0);

        // Power-on accumulate
        run_frame(4'b1111, lat, out, a0);
        chk("pwr_latency", lat, 9);
        chk("pwr_out0", out, 'h40);
        run_frame(4'b1111, lat, out, a0);
        chk("pwr_out1", out, 'h80);

        // Octave control on voice 0
        do_reset();
        pulse(4'b0001, 4'b0000, 3);
        run_frame(4'b1111, lat, out, a0);
        chk("oct_addr0", a0, 0);
        run_frame(4'b1111, lat, out, a0);
        chk("oct_addr1", a0, 8);
        pulse(4'b0001, 4'b0000, 9);
        run_frame(4'b1111, lat, out, a0);
        run_frame(4'b1111, lat, out, a1);
        chk("oct_sat128", pdiff(a0, a1), 128);
        pulse(4'b0000, 4'b0001, 10);
        run_frame(4'b1111, lat, out, a0);
        run_frame(4'b1111, lat, out, a1);
        chk("oct_min1", pdiff(a0, a1), 1);
        pulse(4'b0001, 4'b0001, 1);
        run_frame(4'b1111, lat, out, a0);
        run_frame(4'b1111, lat, out, a1);
        chk("oct_updown_hold", pdiff(a0, a1), 1);

        // Wrap-around of voice 0 phase
        do_reset();
        pulse(4'b0001, 4'b0000, 1);
        repeat (2047) run_frame(4'b0001, lat, out, a0);
        pulse(4'b0001, 4'b0000, 1);
        run_frame(4'b0001, lat, out, a0);
        chk("wrap_addr4094", a0, 4094);
        run_frame(4'b0001, lat, out, a0);
        chk("wrap_addr2", a0, 2);

        // Backpressure with a dropped tick
        voice_en = 4'b1111;
        sample_tick = 1'b1;
        nxt();
        sample_tick = 1'b0;
        k = 0;
        while (!agg_valid && k < 40) begin nxt(); k++; end
        saved = agg_out;
        ovr_cnt = 0;
        stable = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) sample_tick = 1'b1;
            nxt();
            sample_tick = 1'b0;
            if (overrun) ovr_cnt++;
            if (!agg_valid || agg_out !== saved) stable = 0;
        end
        chk("bp_overrun_pulses", ovr_cnt, 1);
        chk("bp_stable", int'(stable), 1);
        agg_ack = 1'b1;
        nxt();
        agg_ack = 1'b0;
        chk("bp_valid_after_ack", int'(agg_valid), 0);
        chk("bp_busy_after_ack", int'(busy), 0);

        // Disabled voices
        do_reset();
        run_frame(4'b0101, lat, out, a0);
        chk("dis_latency_0101", lat, 7);
        chk("dis_out_0101", out, 'h20);
        run_frame(4'b0000, lat, out, a0);
        chk("dis_latency_0000", lat, 5);
        chk("dis_out_0000", out, 0);

        // Reset during voice 2 ACCUM
        voice_en = 4'b1111;
        sample_tick = 1'b1;
        nxt();
        sample_tick = 1'b0;
        repeat (5) nxt();
        rst = 1'b1;
        nxt();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_valid", int'(agg_valid), 0);
        chk("rst_mid_lut_rd", int'(lut_rd), 0);
        rst = 1'b0;
        run_frame(4'b1111, lat, out, a0);
        chk("rst_mid_addr0", a0, 0);
        chk("rst_mid_out", out, 'h40);

        // Randomized traffic; voice_en only moves while idle.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            sample_tick = ($urandom_range(0, 5) == 0);
            if (!busy) voice_en = 4'($urandom);
            for (int b = 0; b < NV; b++) begin
                o_up[b]   = ($urandom_range(0, 15) == 0);
                o_down[b] = ($urandom_range(0, 15) == 0);
            end
            agg_ack = ($urandom_range(0, 2) == 0);
            nxt();
        end
        rst = 1'b0; sample_tick = 1'b0; o_up = '0; o_down = '0; agg_ack = 1'b1;
        repeat (30) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_voice_sched.md
Name: note_voice_sched

Overview:
- Time-multiplexes one shared waveform LUT read port across NUM_VOICES note voices.
- Each voice keeps its own phase index and octave step register, with up/down octave control.
- On every sample_tick, the block visits each voice in order, reads the LUT at that voice's phase, sums the samples and advances the phases.
- The summed sample goes to the downstream aggregator over a valid/ack handshake.

Parameters:
- NUM_VOICES, 4, number of voices. Legal values 2..8.
- IDX_W, 12, LUT address width and phase index width.
- STEP_W, 8, step register width.
- SAMP_W, 8, LUT data width, unsigned.
- MIX_W, SAMP_W+3, mix accumulator and output width. Must be ≥ SAMP_W+clog2(NUM_VOICES).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse that starts a frame.
- voice_en  in  NUM_VOICES  per-voice enable.
- o_up  in  NUM_VOICES  one-cycle pulse per voice: raise one octave.
- o_down  in  NUM_VOICES  one-cycle pulse per voice: lower one octave.
- lut_rd  out  1  LUT read strobe.
- lut_addr  out  IDX_W  LUT address.
- lut_data  in  SAMP_W  LUT read data; valid exactly one cycle after lut_rd.
- agg_out  out  MIX_W  mixed sample.
- agg_valid  out  1  agg_out is valid.
- agg_ack  in  1  downstream accepts agg_out.
- busy  out  1  high when the FSM is not in IDLE.
- overrun  out  1  one-cycle pulse when a sample_tick is dropped.

Behaviour:
- Reset values (synchronous, takes priority over everything):
  - state IDLE, voice counter 0.
  - every phase register 0; every step register 1.
  - accumulator 0, agg_out 0.
  - agg_valid, lut_rd, busy and overrun all 0.
- Step registers (updated every cycle, independent of the FSM):
  - o_up alone: step <<= 1, saturating at 2^(STEP_W-1) (128 at the default width).
  - o_down alone: step >>= 1, clamped to a minimum of 1.
  - o_up and o_down in the same cycle: no change.
- Phase arithmetic:
  - phase[v] <= (phase[v] + step[v]) mod 2^IDX_W.
  - Uses the step value registered before this cycle; a same-cycle step update does not affect it.
- FSM states: IDLE, ISSUE, ACCUM, PRESENT.
  - IDLE: on sample_tick, clear the accumulator, set v=0, go to ISSUE.
  - ISSUE, voice_en[v]=1: drive lut_rd=1 and lut_addr=phase[v] for this cycle only, go to ACCUM.
  - ISSUE, voice_en[v]=0: phase[v] holds. If v==NUM_VOICES-1 go to PRESENT, else v++ and stay in ISSUE.
  - ACCUM: acc += lut_data (zero-extended) and advance phase[v]. If v==NUM_VOICES-1 go to PRESENT, else v++ and go to ISSUE.
  - PRESENT: agg_out=acc and agg_valid=1, both held stable until agg_ack is sampled high. In that cycle the transfer completes; agg_valid is 0 the next cycle and the FSM returns to IDLE.
- lut_rd is 0 in every state except an enabled-voice ISSUE. lut_addr is don't-care when lut_rd=0.
- voice_en[v] is sampled only in voice v's ISSUE cycle; changes mid-frame affect only voices not yet visited.
- Latency, for a tick at cycle T:
  - ISSUE for v0 at T+1.
  - Each enabled voice costs 2 cycles; each disabled voice costs 1 cycle.
  - agg_valid rises at T+1+cost. All 4 voices enabled: T+9. All disabled: T+5 with agg_out=0.
- sample_tick outside IDLE: the tick is ignored and overrun pulses for 1 cycle. There is no frame queueing.
- agg_ack outside PRESENT is ignored.
- The accumulator cannot overflow given the MIX_W constraint.
- rst asserted mid-frame: the next cycle is IDLE with all reset values. An in-flight LUT read is discarded.

Test Plan:
- Power-on accumulate: rst, then all 4 voices enabled. LUT model returns 0x10 at addr 0 and 0x20 at addr 1. Tick → agg_valid at T+9 with agg_out=0x040. Ack, tick again → agg_out=0x080.
- Octave control on voice0: 3× o_up pulses, then two ticks (acked) → voice0 addresses 0 then 8. 9× o_up → step saturates at 128. 10× o_down → step 1. o_up with o_down in the same cycle → step unchanged.
- Wrap-around: preload phase0 to 4094 (4094 ticks at step 1, or 2047 at step 2). With step 4 → next addr 4094, then 2.
- Backpressure: hold agg_ack low 12 cycles after agg_valid and issue a tick during PRESENT → overrun 1-cycle pulse, agg_out and agg_valid stable throughout. Ack → agg_valid 0 next cycle, busy 0.
- Disabled voices: voice_en=4'b0101 → only addrs for v0 and v2 issued, agg_valid at T+7, phases of v1 and v3 unchanged. All disabled → agg_valid at T+5, agg_out=0.
- Reset mid-frame: rst in voice2's ACCUM cycle → next cycle busy=0, agg_valid=0, lut_rd=0. Next tick reads addr 0 for every voice.
